// File: rtl/acia_uart.sv
// 6850-style ACIA: one 8N1 UART with status/control and data registers on the SoC bus.
// Read data is registered; irq is decoded from registered state.
module acia_uart #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic       rs,
  input  logic       rx,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       tx,
  output logic       irq
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic rxie_q, txie_q, rdrf_q, tdre_q, fe_q, ovrn_q;
  logic [7:0] thr_q, rx_data_q;

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_idx_q, tx_idx_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic          tx_bit_end_c, tx_free_c, tx_load_c;

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [1:0]    rx_sync_q;
  logic          rx_prev_q, rx_fall_c, rx_done_c;

  logic wr_ctrl_c, wr_data_c, rd_c, rd_data_c;

  assign wr_ctrl_c = cs & we & ~rs;
  assign wr_data_c = cs & we & rs;
  assign rd_c      = cs & ~we;
  assign rd_data_c = rd_c & rs;

  assign irq = (rxie_q & rdrf_q) | (txie_q & tdre_q);

  // Transmitter: the shifter is free on the edge that ends the stop bit, so frames run back to back.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_idx_d     = tx_idx_q;
    tx_shift_d   = tx_shift_q;
    tx_load_c    = 1'b0;
    tx_bit_end_c = (tx_cnt_q == BIT_LAST);
    tx_free_c    = (tx_state_q == TX_IDLE) || (tx_bit_end_c && tx_idx_q == 4'd9);
    case (tx_state_q)
      TX_IDLE: ;
      TX_BUSY: begin
        if (tx_bit_end_c) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 4'd9) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_idx_d   = tx_idx_q + 4'd1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_free_c && !tdre_q) begin
      tx_load_c  = 1'b1;
      tx_state_d = TX_BUSY;
      tx_shift_d = {1'b1, thr_q, 1'b0};
      tx_cnt_d   = '0;
      tx_idx_d   = '0;
    end
  end

  // Receiver: start bit checked at half a bit, then every bit sampled one full bit later.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_done_c  = 1'b0;
    rx_fall_c  = rx_prev_q & ~rx_sync_q[1];
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall_c) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q[1] ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q[1], rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_done_c  = 1'b1;
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // State machine and shifter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '1;
      tx         <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx         <= (tx_state_q == TX_BUSY) ? tx_shift_q[0] : 1'b1;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_sync_q  <= {rx_sync_q[0], rx};
      rx_prev_q  <= rx_sync_q[1];
    end
  end

  // Bus registers; a data read coinciding with frame completion clears first, then loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxie_q    <= 1'b0;
      txie_q    <= 1'b0;
      rdrf_q    <= 1'b0;
      tdre_q    <= 1'b1;
      fe_q      <= 1'b0;
      ovrn_q    <= 1'b0;
      thr_q     <= '0;
      rx_data_q <= '0;
      dout      <= '0;
    end else begin
      if (wr_ctrl_c) begin
        rxie_q <= din[0];
        txie_q <= din[1];
      end
      if (wr_data_c && tdre_q) begin
        thr_q  <= din;
        tdre_q <= 1'b0;
      end else if (tx_load_c) begin
        tdre_q <= 1'b1;
      end
      if (rx_done_c) begin
        if (rdrf_q && !rd_data_c) begin
          ovrn_q <= 1'b1;
        end else begin
          rx_data_q <= rx_shift_q;
          rdrf_q    <= 1'b1;
          fe_q      <= ~rx_sync_q[1];
          ovrn_q    <= 1'b0;
        end
      end else if (rd_data_c) begin
        rdrf_q <= 1'b0;
        fe_q   <= 1'b0;
        ovrn_q <= 1'b0;
      end
      if (rd_c) begin
        dout <= rs ? rx_data_q : {irq, 1'b0, ovrn_q, fe_q, 2'b00, tdre_q, rdrf_q};
      end
    end
  end

endmodule

// File: tb/tb_acia_uart.sv
// Bench for acia_uart: directed bus/serial scenarios plus randomized receive traffic
// checked against a transaction-level register model.
module tb_acia_uart;
  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b0, we = 1'b0, rs = 1'b0, rx = 1'b1;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       tx, irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // register model
  logic       m_rxie = 0, m_txie = 0, m_rdrf = 0, m_tdre = 1, m_fe = 0, m_ovrn = 0;
  logic [7:0] m_data = '0;

  // transmit capture
  logic       mon_en = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];
  int         got_t[$];

  acia_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .rs(rs), .rx(rx),
    .din(din), .dout(dout), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_irq();
    return (m_rxie & m_rdrf) | (m_txie & m_tdre);
  endfunction

  function automatic logic [7:0] m_status();
    return {m_irq(), 1'b0, m_ovrn, m_fe, 2'b00, m_tdre, m_rdrf};
  endfunction

  // Bus tasks start and end at a falling edge.
  task automatic bus_wr(input logic r, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; rs = r; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic r, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; rs = r;
    @(negedge clk);
    cs = 1'b0;
    d = dout;
  endtask

  task automatic chk_status(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    e = m_status();
    bus_rd(1'b0, v);
    chk(tag, 32'(v), 32'(e));
  endtask

  task automatic chk_data(input string tag);
    logic [7:0] v;
    bus_rd(1'b1, v);
    chk(tag, 32'(v), 32'(m_data));
    m_rdrf = 0; m_fe = 0; m_ovrn = 0;
  endtask

  task automatic set_ctrl(input logic [1:0] c);
    bus_wr(1'b0, {6'b0, c});
    m_rxie = c[0];
    m_txie = c[1];
  endtask

  // Drive one serial frame, then update the model with the frame outcome.
  task automatic rx_send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    if (m_rdrf) begin
      m_ovrn = 1;
    end else begin
      m_data = b;
      m_rdrf = 1;
      m_fe   = ~stop;
    end
  endtask

  // Transmit monitor: decodes frames mid-bit and records start cycle.
  initial begin
    int         t0;
    logic [7:0] b;
    logic       sb;
    forever begin
      @(negedge clk);
      if (mon_en && tx == 1'b0) begin
        t0 = cyc;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        sb = tx;
        chk("tx_stop_bit", 32'(sb), 32'd1);
        got_tx.push_back(b);
        got_t.push_back(t0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] b1, b2, b3, rb;
    int         op;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a transmitted start bit
    bus_wr(1'b1, 8'hC3);
    repeat (4) @(negedge clk);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_tx_async", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_rxie = 0; m_txie = 0; m_rdrf = 0; m_tdre = 1; m_fe = 0; m_ovrn = 0; m_data = '0;
    @(negedge clk);
    chk("rst_tx_after", 32'(tx), 32'd1);
    chk_status("rst_status");

    // Transmit 0x55 with exact bit timing
    bus_wr(1'b1, 8'h55);
    m_tdre = 0;
    chk_status("tdre_low_n1");
    chk("tx_idle_n1", 32'(tx), 32'd1);
    m_tdre = 1;
    chk_status("tdre_back_n2");
    fr = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("tx55_bit%0d_first", k), 32'(tx), 32'(fr[k]));
      repeat (CPB - 1) @(negedge clk);
      chk($sformatf("tx55_bit%0d_last", k), 32'(tx), 32'(fr[k]));
      @(negedge clk);
    end
    chk("tx55_idle", 32'(tx), 32'd1);
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    // Receive 0xA5
    rx_send(8'hA5, 1'b1);
    chk_status("rx_a5_status");
    chk_data("rx_a5_data");
    chk_status("rx_a5_status2");

    // Receive interrupt, then transmit interrupt
    set_ctrl(2'b01);
    chk("irq_idle", 32'(irq), 32'(m_irq()));
    rx_send(8'h3C, 1'b1);
    chk("irq_rx", 32'(irq), 32'd1);
    chk_data("rx_3c_data");
    chk("irq_rx_clr", 32'(irq), 32'd0);
    set_ctrl(2'b10);
    chk("irq_tx", 32'(irq), 32'd1);
    set_ctrl(2'b00);

    // Overrun, then framing error
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    chk_status("ovrn_status");
    chk_data("ovrn_data");
    chk_status("ovrn_cleared");
    rx_send(8'h7E, 1'b0);
    chk_status("fe_status");
    chk_data("fe_data");

    // Short low glitch on rx must not produce a byte
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk_status("glitch_status");

    // Consecutive data writes: second is discarded
    cs = 1'b1; we = 1'b1; rs = 1'b1; din = 8'h01;
    @(negedge clk);
    din = 8'h02;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    exp_tx.push_back(8'h01);
    repeat (100) @(negedge clk);

    // Back-to-back frames through the holding register
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    b3 = 8'($urandom);
    bus_wr(1'b1, b1);
    exp_tx.push_back(b1);
    repeat (3) @(negedge clk);
    bus_wr(1'b1, b2);
    exp_tx.push_back(b2);
    m_tdre = 0;
    chk_status("tdre_held");
    bus_wr(1'b1, b3);
    repeat (200) @(negedge clk);
    m_tdre = 1;
    chk_status("tdre_drained");

    chk("tx_frames", 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      chk($sformatf("tx_byte%0d", i), 32'(got_tx[i]), 32'(exp_tx[i]));
    if (got_t.size() == 3)
      chk("tx_no_gap", 32'(got_t[2] - got_t[1]), 32'(10 * CPB));
    else
      chk("tx_gap_frames", 32'(got_t.size()), 32'd3);

    // Randomized receive traffic and control writes against the model
    for (int n = 0; n < 30; n++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0, 1: begin
          rb = 8'($urandom);
          rx_send(rb, ($urandom_range(0, 4) != 0));
        end
        2: chk_status($sformatf("rnd%0d_status", n));
        3: chk_data($sformatf("rnd%0d_data", n));
        default: begin
          set_ctrl(2'($urandom_range(0, 3)));
          chk($sformatf("rnd%0d_irq", n), 32'(irq), 32'(m_irq()));
        end
      endcase
    end
    chk_status("final_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
